rtl_sim_receiver: RTL and testbench

RTL_SIM_RECEIVER -- requirements
Module: rtl_sim_receiver

---
 rtl/rtl_sim_receiver.sv | 206 ++++++++++++++++++++
 tb/tb_rtl_sim_receiver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtl_sim_receiver.sv
// ---------------------------------------------------------------------------
// rtl_sim_receiver
//
// Behavioural stand-in for the far end of a reliable transport link.
// Every segment the sender emits is either dropped by a pseudo-random loss
// model, or delayed by a fixed round-trip time and answered with a
// cumulative ACK / DUPACK. The answer depends on the per-flow next-expected
// sequence number.
//
// Parameters
//   RTT        cycles from segment sample to registered response (1..255)
//   LOSS_PROB  drop probability in 1/1024 units (0..1024)
//   FLOW_CNT   number of tracked flows, flow IDs 1..FLOW_CNT
//   DEPTH      in-flight queue entries (power of 2, >= 2)
//   SEQ_W, TX_W, FID_W, PKT_TYPE_W, DATA_W (>= TX_W+SEQ_W), LFSR_SEED (!= 0)
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   next_seq_in                sequence number of the segment sent this cycle
//   next_seq_tx_id_in          transmission attempt ID of that segment
//   next_seq_fid_in            flow ID, 0 = no segment this cycle
//   resp_fid                   flow of the response, 0 when idle
//   resp_pkt_type              0 NONE, 1 ACK, 2 DUPACK
//   resp_pkt_data              {zero pad, tx_id, cumulative next-expected seq}
//   lost_cnt                   segments dropped by the loss model (saturating)
//   ovf_cnt                    segments dropped on a full queue (saturating)
// ---------------------------------------------------------------------------
module rtl_sim_receiver #(
    parameter int          RTT        = 8,
    parameter int          LOSS_PROB  = 0,
    parameter int          FLOW_CNT   = 4,
    parameter int          DEPTH      = 16,
    parameter int          SEQ_W      = 32,
    parameter int          TX_W       = 4,
    parameter int          FID_W      = 8,
    parameter int          PKT_TYPE_W = 2,
    parameter int          DATA_W     = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEQ_W-1:0]      next_seq_in,
    input  logic [TX_W-1:0]       next_seq_tx_id_in,
    input  logic [FID_W-1:0]      next_seq_fid_in,
    output logic [FID_W-1:0]      resp_fid,
    output logic [PKT_TYPE_W-1:0] resp_pkt_type,
    output logic [DATA_W-1:0]     resp_pkt_data,
    output logic [15:0]           lost_cnt,
    output logic [15:0]           ovf_cnt
);

    localparam int                    AW        = $clog2(DEPTH);
    localparam logic [PKT_TYPE_W-1:0] PKT_NONE  = PKT_TYPE_W'(0);
    localparam logic [PKT_TYPE_W-1:0] PKT_ACK   = PKT_TYPE_W'(1);
    localparam logic [PKT_TYPE_W-1:0] PKT_DUP   = PKT_TYPE_W'(2);
    localparam logic [FID_W-1:0]      FID_MAX   = FID_W'(FLOW_CNT);
    localparam logic [11:0]           LOSS_TH   = 12'(LOSS_PROB);
    localparam logic [7:0]            AGE_POP   = 8'(RTT - 1);
    localparam logic [AW:0]           CNT_FULL  = (AW + 1)'(DEPTH);
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0]           LFSR_TAPS = 16'hB400;
    localparam logic [15:0]           SAT       = 16'hFFFF;

    typedef struct packed {
        logic [FID_W-1:0] fid;
        logic [SEQ_W-1:0] seq;
        logic [TX_W-1:0]  tx_id;
        logic [7:0]       ts;
    } entry_t;

    // ---------------------------------------------------------------- state
    entry_t                mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q,  count_d;
    logic [7:0]            tick_q,   tick_d;
    logic [15:0]           lfsr_q,   lfsr_d;
    logic [SEQ_W-1:0]      exp_q [FLOW_CNT];
    logic [SEQ_W-1:0]      exp_d [FLOW_CNT];
    logic [FID_W-1:0]      resp_fid_q,  resp_fid_d;
    logic [PKT_TYPE_W-1:0] resp_type_q, resp_type_d;
    logic [DATA_W-1:0]     resp_data_q, resp_data_d;
    logic [15:0]           lost_q, lost_d;
    logic [15:0]           ovf_q,  ovf_d;

    // -------------------------------------------------------- combinational
    logic             seg_valid;
    logic             seg_lost;
    logic             full;
    logic             pop;
    logic             push;
    logic             ovf_inc;
    logic [11:0]      loss_margin;
    entry_t           head;
    entry_t           push_ent;
    logic [SEQ_W-1:0] head_exp;
    logic [SEQ_W-1:0] ack_seq;

    always_comb begin
        tick_d = tick_q + 8'd1;
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        seg_valid = (next_seq_fid_in != '0) && (next_seq_fid_in <= FID_MAX);

        // Drop when LFSR[9:0] < LOSS_PROB. Done as a signed margin so the
        // test stays meaningful for LOSS_PROB = 0 without a constant compare.
        loss_margin = LOSS_TH - {2'b00, lfsr_q[9:0]};
        seg_lost    = seg_valid && !loss_margin[11] && (loss_margin != '0);

        full = (count_q == CNT_FULL);
        head = mem_q[rd_ptr_q];
        // Timestamps hold the post-edge tick, so an age of RTT-1 seen before
        // an edge means the segment was sampled exactly RTT edges earlier.
        pop     = (count_q != '0) && ((tick_q - head.ts) == AGE_POP);
        push    = seg_valid && !seg_lost && (!full || pop);
        ovf_inc = seg_valid && !seg_lost && full && !pop;

        push_ent.fid   = next_seq_fid_in;
        push_ent.seq   = next_seq_in;
        push_ent.tx_id = next_seq_tx_id_in;
        push_ent.ts    = tick_d;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        head_exp = '0;
        for (int f = 0; f < FLOW_CNT; f++) begin
            if (head.fid == FID_W'(f + 1)) head_exp = exp_q[f];
        end

        exp_d       = exp_q;
        ack_seq     = head.seq + SEQ_W'(1);
        resp_fid_d  = '0;
        resp_type_d = PKT_NONE;
        resp_data_d = '0;
        if (pop) begin
            resp_fid_d                  = head.fid;
            resp_data_d[SEQ_W +: TX_W]  = head.tx_id;
            if (head.seq == head_exp) begin
                resp_type_d              = PKT_ACK;
                resp_data_d[SEQ_W-1:0]   = ack_seq;
                for (int f = 0; f < FLOW_CNT; f++) begin
                    if (head.fid == FID_W'(f + 1)) exp_d[f] = ack_seq;
                end
            end else begin
                // Out of order: no buffering, just re-advertise what we want.
                resp_type_d              = PKT_DUP;
                resp_data_d[SEQ_W-1:0]   = head_exp;
            end
        end

        lost_d = lost_q;
        if (seg_lost && (lost_q != SAT)) lost_d = lost_q + 16'd1;
        ovf_d = ovf_q;
        if (ovf_inc && (ovf_q != SAT)) ovf_d = ovf_q + 16'd1;
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tick_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            resp_fid_q  <= '0;
            resp_type_q <= PKT_NONE;
            resp_data_q <= '0;
            lost_q      <= '0;
            ovf_q       <= '0;
            for (int f = 0; f < FLOW_CNT; f++) exp_q[f] <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            lfsr_q      <= lfsr_d;
            resp_fid_q  <= resp_fid_d;
            resp_type_q <= resp_type_d;
            resp_data_q <= resp_data_d;
            lost_q      <= lost_d;
            ovf_q       <= ovf_d;
            exp_q       <= exp_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_ent;
    end

    assign resp_fid      = resp_fid_q;
    assign resp_pkt_type = resp_type_q;
    assign resp_pkt_data = resp_data_q;
    assign lost_cnt      = lost_q;
    assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_rtl_sim_receiver.sv
// ---------------------------------------------------------------------------
// tb_rtl_sim_receiver
//
// Five receivers with different parameter sets share one stimulus stream:
//   u0 defaults, u1 full loss, u2 shallow queue, u3 RTT 5 / 40% loss /
//   DEPTH 4 / 3 flows, u4 RTT 1 / DEPTH 2 / 8-bit sequence numbers.
// A reference model tracks every instance as a list of (segment, due edge)
// records and is compared against all outputs on every falling edge.
// Directed sequences add named checks on top of that.
// ---------------------------------------------------------------------------
module tb_rtl_sim_receiver;

    localparam int NI = 5;

    logic        clk;
    logic        rst_n;
    logic [31:0] seq_in;
    logic [3:0]  tx_in;
    logic [7:0]  fid_in;

    logic [NI-1:0][7:0]  o_fid;
    logic [NI-1:0][1:0]  o_type;
    logic [NI-2:0][63:0] o_data;
    logic [15:0]         d4;
    logic [NI-1:0][15:0] o_lost;
    logic [NI-1:0][15:0] o_ovf;

    rtl_sim_receiver u0 (
        .clk(clk), .rst_n(rst_n), .next_seq_in(seq_in), .next_seq_tx_id_in(tx_in),
        .next_seq_fid_in(fid_in), .resp_fid(o_fid[0]), .resp_pkt_type(o_type[0]),
        .resp_pkt_data(o_data[0]), .lost_cnt(o_lost[0]), .ovf_cnt(o_ovf[0]));
    rtl_sim_receiver #(.LOSS_PROB(1024)) u1 (
        .clk(clk), .rst_n(rst_n), .next_seq_in(seq_in), .next_seq_tx_id_in(tx_in),
        .next_seq_fid_in(fid_in), .resp_fid(o_fid[1]), .resp_pkt_type(o_type[1]),
        .resp_pkt_data(o_data[1]), .lost_cnt(o_lost[1]), .ovf_cnt(o_ovf[1]));
    rtl_sim_receiver #(.DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .next_seq_in(seq_in), .next_seq_tx_id_in(tx_in),
        .next_seq_fid_in(fid_in), .resp_fid(o_fid[2]), .resp_pkt_type(o_type[2]),
        .resp_pkt_data(o_data[2]), .lost_cnt(o_lost[2]), .ovf_cnt(o_ovf[2]));
    rtl_sim_receiver #(.RTT(5), .LOSS_PROB(400), .DEPTH(4), .FLOW_CNT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .next_seq_in(seq_in), .next_seq_tx_id_in(tx_in),
        .next_seq_fid_in(fid_in), .resp_fid(o_fid[3]), .resp_pkt_type(o_type[3]),
        .resp_pkt_data(o_data[3]), .lost_cnt(o_lost[3]), .ovf_cnt(o_ovf[3]));
    rtl_sim_receiver #(.RTT(1), .DEPTH(2), .SEQ_W(8), .DATA_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .next_seq_in(seq_in[7:0]), .next_seq_tx_id_in(tx_in),
        .next_seq_fid_in(fid_in), .resp_fid(o_fid[4]), .resp_pkt_type(o_type[4]),
        .resp_pkt_data(d4), .lost_cnt(o_lost[4]), .ovf_cnt(o_ovf[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------ per-instance settings
    function automatic int p_rtt(int i);
        case (i) 3: return 5; 4: return 1; default: return 8; endcase
    endfunction
    function automatic int p_loss(int i);
        case (i) 1: return 1024; 3: return 400; default: return 0; endcase
    endfunction
    function automatic int p_depth(int i);
        case (i) 2: return 4; 3: return 4; 4: return 2; default: return 16; endcase
    endfunction
    function automatic int p_flows(int i);
        return (i == 3) ? 3 : 4;
    endfunction

    // ------------------------------------------------------ reference model
    int          m_edge [NI];
    logic [15:0] m_lfsr [NI];
    int          m_lost [NI];
    int          m_ovf  [NI];
    logic [31:0] m_exp  [NI][5];
    logic [7:0]  q_fid  [NI][256];
    logic [31:0] q_seq  [NI][256];
    logic [3:0]  q_tx   [NI][256];
    int          q_due  [NI][256];
    int          q_hd   [NI];
    int          q_tl   [NI];
    logic [7:0]  e_fid  [NI];
    logic [1:0]  e_type [NI];
    logic [63:0] e_data [NI];

    task automatic model_reset(int i);
        m_edge[i] = 0;
        m_lfsr[i] = 16'hACE1;
        m_lost[i] = 0;
        m_ovf[i]  = 0;
        for (int f = 0; f < 5; f++) m_exp[i][f] = 0;
        q_hd[i] = 0;
        q_tl[i] = 0;
        e_fid[i] = 0; e_type[i] = 0; e_data[i] = 0;
    endtask

    task automatic model_step(int i, logic [7:0] fid, logic [31:0] seq, logic [3:0] tx);
        logic [31:0] mask = (i == 4) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        int          sw   = (i == 4) ? 8 : 32;
        bit          popped = 0;
        int          h;
        logic [31:0] want;
        m_edge[i]++;
        e_fid[i] = 0; e_type[i] = 0; e_data[i] = 0;
        if (q_tl[i] != q_hd[i] && q_due[i][q_hd[i] % 256] == m_edge[i]) begin
            h = q_hd[i] % 256;
            popped = 1;
            q_hd[i]++;
            want = m_exp[i][q_fid[i][h]];
            e_fid[i] = q_fid[i][h];
            if (q_seq[i][h] == want) begin
                e_type[i] = 2'd1;
                want = (want + 1) & mask;
                m_exp[i][q_fid[i][h]] = want;
            end else begin
                e_type[i] = 2'd2;
            end
            e_data[i] = ({60'b0, q_tx[i][h]} << sw) | {32'b0, want};
        end
        if (int'(fid) >= 1 && int'(fid) <= p_flows(i)) begin
            if (int'(m_lfsr[i][9:0]) < p_loss(i)) begin
                if (m_lost[i] < 65535) m_lost[i]++;
            end else if (q_tl[i] - q_hd[i] == p_depth(i) && !popped) begin
                if (m_ovf[i] < 65535) m_ovf[i]++;
            end else begin
                h = q_tl[i] % 256;
                q_fid[i][h] = fid;
                q_seq[i][h] = seq & mask;
                q_tx[i][h]  = tx;
                q_due[i][h] = m_edge[i] + p_rtt(i);
                q_tl[i]++;
            end
        end
        m_lfsr[i] = {1'b0, m_lfsr[i][15:1]} ^ (m_lfsr[i][0] ? 16'hB400 : 16'h0000);
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) model_reset(i);
            else        model_step(i, fid_in, seq_in, tx_in);
        end
    end

    // ------------------------------------------------------------ checking
    int n_chk  = 0;
    int n_pass = 0;
    int acks2  = 0;
    int resp0  = 0;
    int resp1  = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.resp_fid", i),  64'(o_fid[i]),  64'(e_fid[i]));
            chk($sformatf("u%0d.resp_type", i), 64'(o_type[i]), 64'(e_type[i]));
            if (i == 4) chk("u4.resp_data", {48'b0, d4}, e_data[4]);
            else        chk($sformatf("u%0d.resp_data", i), o_data[i], e_data[i]);
            chk($sformatf("u%0d.lost_cnt", i), 64'(o_lost[i]), 64'(m_lost[i]));
            chk($sformatf("u%0d.ovf_cnt", i),  64'(o_ovf[i]),  64'(m_ovf[i]));
        end
    endtask

    // Drive one cycle of stimulus (called at a falling edge), then check.
    task automatic cyc(input logic [7:0] f, input logic [31:0] s, input logic [3:0] t);
        fid_in = f; seq_in = s; tx_in = t;
        @(posedge clk);
        @(negedge clk);
        check_all();
        if (o_type[2] == 2'd1) acks2++;
        if (o_type[0] != 2'd0) resp0++;
        if (o_type[1] != 2'd0) resp1++;
    endtask

    task automatic idle(int n);
        repeat (n) cyc(8'd0, 32'd0, 4'd0);
    endtask

    task automatic expect0(string nm, logic [7:0] f, logic [1:0] t, logic [63:0] d);
        chk({nm, ".fid"},  64'(o_fid[0]),  64'(f));
        chk({nm, ".type"}, 64'(o_type[0]), 64'(t));
        chk({nm, ".data"}, o_data[0], d);
    endtask

    // Assert reset at a falling edge; outputs must clear without a clock.
    task automatic do_reset(int n);
        rst_n = 1'b0;
        fid_in = '0; seq_in = '0; tx_in = '0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst u%0d fid", i),  64'(o_fid[i]),  64'd0);
            chk($sformatf("rst u%0d type", i), 64'(o_type[i]), 64'd0);
            chk($sformatf("rst u%0d lost", i), 64'(o_lost[i]), 64'd0);
            chk($sformatf("rst u%0d ovf", i),  64'(o_ovf[i]),  64'd0);
        end
        chk("rst u0 data", o_data[0], 64'd0);
        chk("rst u4 data", {48'b0, d4}, 64'd0);
        idle(n);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  fid;
        logic [31:0] seq;
        logic [3:0]  tx;
        logic [7:0]  e_fid;
        logic [1:0]  e_type;
        logic [63:0] e_data;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] nxt [6];

    initial begin
        // In-order stream on flow 1 starting at edge 10: ACKs at rows 8..10.
        for (int r = 0; r < 12; r++) begin
            tbl[r].fid    = (r < 3) ? 8'd1 : 8'd0;
            tbl[r].seq    = (r < 3) ? 32'(r) : 32'd0;
            tbl[r].tx     = (r < 3) ? 4'(r + 5) : 4'd0;
            tbl[r].e_fid  = 8'd0;
            tbl[r].e_type = 2'd0;
            tbl[r].e_data = 64'd0;
        end
        for (int r = 8; r < 11; r++) begin
            tbl[r].e_fid  = 8'd1;
            tbl[r].e_type = 2'd1;
            tbl[r].e_data = (64'(r - 3) << 32) | 64'(r - 7);
        end

        rst_n = 1'b0; fid_in = '0; seq_in = '0; tx_in = '0;
        repeat (2) @(negedge clk);
        do_reset(3);

        idle(9);
        for (int r = 0; r < 12; r++) begin
            cyc(tbl[r].fid, tbl[r].seq, tbl[r].tx);
            expect0($sformatf("tbl%0d", r), tbl[r].e_fid, tbl[r].e_type, tbl[r].e_data);
        end

        // Out-of-order on flow 2: 0, 2, 1 -> ACK 1, DUPACK 1, ACK 2.
        cyc(8'd2, 32'd0, 4'd1);
        cyc(8'd2, 32'd2, 4'd2);
        cyc(8'd2, 32'd1, 4'd3);
        idle(5);
        cyc(8'd0, 32'd0, 4'd0); expect0("ooo ack1", 8'd2, 2'd1, 64'h1_0000_0001);
        cyc(8'd0, 32'd0, 4'd0); expect0("ooo dup1", 8'd2, 2'd2, 64'h2_0000_0001);
        cyc(8'd0, 32'd0, 4'd0); expect0("ooo ack2", 8'd2, 2'd1, 64'h3_0000_0002);
        cyc(8'd2, 32'd2, 4'd4);
        idle(7);
        cyc(8'd0, 32'd0, 4'd0); expect0("exp2 is 2", 8'd2, 2'd1, 64'h4_0000_0003);

        // Full loss: 20 segments, nothing answered.
        do_reset(2);
        resp1 = 0;
        for (int j = 0; j < 20; j++) cyc(8'(1 + j % 4), 32'(j), 4'(j));
        idle(10);
        chk("loss lost_cnt", 64'(o_lost[1]), 64'd20);
        chk("loss responses", 64'(resp1), 64'd0);

        // Shallow queue: 8 back-to-back, 4 survive.
        do_reset(2);
        acks2 = 0;
        for (int j = 0; j < 8; j++) cyc(8'd1, 32'(j), 4'd0);
        idle(12);
        chk("ovf acks", 64'(acks2), 64'd4);
        chk("ovf ovf_cnt", 64'(o_ovf[2]), 64'd4);

        // Sequence wrap on the 8-bit instance (RTT 1).
        do_reset(2);
        for (int j = 0; j < 255; j++) cyc(8'd3, 32'(j), 4'd0);
        cyc(8'd3, 32'd255, 4'd5);
        cyc(8'd3, 32'd0, 4'd6);
        chk("wrap ack type", 64'(o_type[4]), 64'd1);
        chk("wrap ack data", {48'b0, d4}, 64'h0500);
        cyc(8'd0, 32'd0, 4'd0);
        chk("wrap next fid", 64'(o_fid[4]), 64'd3);
        chk("wrap next data", {48'b0, d4}, 64'h0601);

        // Reset while segments are in flight.
        do_reset(2);
        idle(2);
        cyc(8'd1, 32'd0, 4'd1);
        cyc(8'd1, 32'd1, 4'd2);
        idle(3);
        do_reset(2);
        resp0 = 0;
        idle(12);
        chk("midrst no resp", 64'(resp0), 64'd0);
        cyc(8'd1, 32'd0, 4'd9);
        for (int k = 1; k < 8; k++) begin
            cyc(8'd0, 32'd0, 4'd0);
            chk($sformatf("post-rst idle %0d", k), 64'(o_type[0]), 64'd0);
        end
        cyc(8'd0, 32'd0, 4'd0);
        expect0("post-rst ack", 8'd1, 2'd1, 64'h9_0000_0001);

        // Random traffic, mostly in-order per flow, some invalid IDs.
        do_reset(2);
        for (int f = 0; f < 6; f++) nxt[f] = 0;
        for (int c = 0; c < 1500; c++) begin
            int          f = int'($urandom_range(0, 5));
            logic [31:0] s;
            if ($urandom_range(0, 3) != 0) begin
                s = nxt[f];
                nxt[f] = nxt[f] + 1;
            end else begin
                s = 32'($urandom_range(0, 15));
            end
            cyc(8'(f), s, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
